// File: rtl/user_obi_arbiter.sv
// Round-robin OBI arbiter: N upstream requesters share one downstream port, with
// the request held (locked) until granted and responses routed back in grant order.
module user_obi_arbiter #(
  parameter int NumMgr   = 2,
  parameter int MaxTrans = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NumMgr-1:0]        mgr_req_i,
  input  logic [NumMgr*32-1:0]     mgr_addr_i,
  input  logic [NumMgr-1:0]        mgr_we_i,
  input  logic [NumMgr*4-1:0]      mgr_be_i,
  input  logic [NumMgr*32-1:0]     mgr_wdata_i,
  output logic [NumMgr-1:0]        mgr_gnt_o,
  output logic [NumMgr-1:0]        mgr_rvalid_o,
  output logic [31:0]              mgr_rdata_o,
  output logic                     mgr_err_o,
  output logic                     obi_req_o,
  output logic [31:0]              obi_addr_o,
  output logic                     obi_we_o,
  output logic [3:0]               obi_be_o,
  output logic [31:0]              obi_wdata_o,
  input  logic                     obi_gnt_i,
  input  logic                     obi_rvalid_i,
  input  logic [31:0]              obi_rdata_i,
  input  logic                     obi_err_i,
  output logic                     unexp_rsp_o
);

  localparam int IdxW = (NumMgr > 1) ? $clog2(NumMgr) : 1;
  localparam int PtrW = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
  localparam int CntW = $clog2(MaxTrans + 1);

  localparam logic [CntW-1:0] MaxCnt   = CntW'(MaxTrans);
  localparam logic [IdxW-1:0] LastMgr  = IdxW'(NumMgr - 1);
  localparam logic [PtrW-1:0] LastSlot = PtrW'(MaxTrans - 1);

  logic [IdxW-1:0] rr_ptr_reg, rr_ptr_next;
  logic            lock_reg, lock_next;
  logic [IdxW-1:0] lock_idx_reg, lock_idx_next;
  logic [CntW-1:0] cnt_reg, cnt_next;
  logic [PtrW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PtrW-1:0] rd_ptr_reg, rd_ptr_next;
  logic            unexp_reg, unexp_next;

  logic [IdxW-1:0] fifo_mem [MaxTrans];

  logic [31:0] addr_arr  [NumMgr];
  logic [31:0] wdata_arr [NumMgr];
  logic [3:0]  be_arr    [NumMgr];

  logic [IdxW-1:0] rr_idx;
  logic [IdxW-1:0] sel_idx;
  logic [IdxW-1:0] head_idx;
  logic            fifo_empty;
  logic            handshake;
  logic            pop;

  genvar gi;
  generate
    for (gi = 0; gi < NumMgr; gi++) begin : g_mgr
      assign addr_arr[gi]     = mgr_addr_i[gi*32 +: 32];
      assign wdata_arr[gi]    = mgr_wdata_i[gi*32 +: 32];
      assign be_arr[gi]       = mgr_be_i[gi*4 +: 4];
      assign mgr_gnt_o[gi]    = handshake && (sel_idx == IdxW'(gi));
      assign mgr_rvalid_o[gi] = pop && (head_idx == IdxW'(gi));
    end
  endgenerate

  // Descending scan so the closest requester at or after rr_ptr_reg wins.
  always_comb begin
    rr_idx = rr_ptr_reg;
    for (int k = NumMgr - 1; k >= 0; k--) begin
      if (mgr_req_i[IdxW'((int'(rr_ptr_reg) + k) % NumMgr)]) begin
        rr_idx = IdxW'((int'(rr_ptr_reg) + k) % NumMgr);
      end
    end
  end

  assign sel_idx    = lock_reg ? lock_idx_reg : rr_idx;
  assign fifo_empty = (cnt_reg == '0);
  assign head_idx   = fifo_mem[rd_ptr_reg];

  // Gated by the registered count only, so a same-cycle pop never frees a slot early.
  assign obi_req_o  = rst_ni && (|mgr_req_i) && (cnt_reg != MaxCnt);
  assign handshake  = obi_req_o && obi_gnt_i;
  assign pop        = rst_ni && obi_rvalid_i && !fifo_empty;

  assign obi_addr_o  = rst_ni ? addr_arr[sel_idx]  : '0;
  assign obi_wdata_o = rst_ni ? wdata_arr[sel_idx] : '0;
  assign obi_be_o    = rst_ni ? be_arr[sel_idx]    : '0;
  assign obi_we_o    = rst_ni && mgr_we_i[sel_idx];

  assign mgr_rdata_o = rst_ni ? obi_rdata_i : '0;
  assign mgr_err_o   = rst_ni && obi_err_i;
  assign unexp_rsp_o = unexp_reg;

  always_comb begin
    rr_ptr_next   = rr_ptr_reg;
    lock_next     = lock_reg;
    lock_idx_next = lock_idx_reg;
    cnt_next      = cnt_reg;
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    unexp_next    = unexp_reg;

    if (handshake) begin
      rr_ptr_next = (sel_idx == LastMgr) ? '0 : sel_idx + IdxW'(1);
      lock_next   = 1'b0;
      wr_ptr_next = (wr_ptr_reg == LastSlot) ? '0 : wr_ptr_reg + PtrW'(1);
    end else if (obi_req_o) begin
      lock_next     = 1'b1;
      lock_idx_next = sel_idx;
    end

    if (pop) begin
      rd_ptr_next = (rd_ptr_reg == LastSlot) ? '0 : rd_ptr_reg + PtrW'(1);
    end

    case ({handshake, pop})
      2'b10:   cnt_next = cnt_reg + CntW'(1);
      2'b01:   cnt_next = cnt_reg - CntW'(1);
      default: cnt_next = cnt_reg;
    endcase

    if (obi_rvalid_i && fifo_empty) begin
      unexp_next = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_reg   <= '0;
      lock_reg     <= 1'b0;
      lock_idx_reg <= '0;
      cnt_reg      <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      unexp_reg    <= 1'b0;
    end else begin
      rr_ptr_reg   <= rr_ptr_next;
      lock_reg     <= lock_next;
      lock_idx_reg <= lock_idx_next;
      cnt_reg      <= cnt_next;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      unexp_reg    <= unexp_next;
    end
  end

  // Entry contents need no reset; the pointers and count define validity.
  always_ff @(posedge clk_i) begin
    if (handshake) begin
      fifo_mem[wr_ptr_reg] <= sel_idx;
    end
  end

endmodule

// File: tb/tb_user_obi_arbiter.sv
// Self-checking bench for user_obi_arbiter: directed scenarios plus random traffic
// compared cycle by cycle against a queue-based model of the arbitration rules.
module tb_user_obi_arbiter;
  localparam int N = 2;
  localparam int M = 2;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic [N-1:0]      mgr_req_i = '0;
  logic [N*32-1:0]   mgr_addr_i = '0;
  logic [N-1:0]      mgr_we_i = '0;
  logic [N*4-1:0]    mgr_be_i = '0;
  logic [N*32-1:0]   mgr_wdata_i = '0;
  logic [N-1:0]      mgr_gnt_o;
  logic [N-1:0]      mgr_rvalid_o;
  logic [31:0]       mgr_rdata_o;
  logic              mgr_err_o;
  logic              obi_req_o;
  logic [31:0]       obi_addr_o;
  logic              obi_we_o;
  logic [3:0]        obi_be_o;
  logic [31:0]       obi_wdata_o;
  logic              obi_gnt_i = 1'b0;
  logic              obi_rvalid_i = 1'b0;
  logic [31:0]       obi_rdata_i = '0;
  logic              obi_err_i = 1'b0;
  logic              unexp_rsp_o;

  user_obi_arbiter #(.NumMgr(N), .MaxTrans(M)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .mgr_req_i(mgr_req_i), .mgr_addr_i(mgr_addr_i), .mgr_we_i(mgr_we_i),
    .mgr_be_i(mgr_be_i), .mgr_wdata_i(mgr_wdata_i),
    .mgr_gnt_o(mgr_gnt_o), .mgr_rvalid_o(mgr_rvalid_o),
    .mgr_rdata_o(mgr_rdata_o), .mgr_err_o(mgr_err_o),
    .obi_req_o(obi_req_o), .obi_addr_o(obi_addr_o), .obi_we_o(obi_we_o),
    .obi_be_o(obi_be_o), .obi_wdata_o(obi_wdata_o), .obi_gnt_i(obi_gnt_i),
    .obi_rvalid_i(obi_rvalid_i), .obi_rdata_i(obi_rdata_i), .obi_err_i(obi_err_i),
    .unexp_rsp_o(unexp_rsp_o)
  );

  always #5 clk_i = ~clk_i;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: next search start, locked requester (-1 = none),
  // outstanding requester indices in grant order, sticky unexpected flag.
  int rr_m = 0;
  int lock_m = -1;
  int q_m[$];
  bit unexp_m = 1'b0;

  logic [N-1:0] obs_gnt, obs_rvalid;
  logic         obs_req, obs_unexp;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    rr_m = 0;
    lock_m = -1;
    q_m.delete();
    unexp_m = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_obi_req"}, obi_req_o, 0);
    check_eq({tag, "_gnt"}, mgr_gnt_o, 0);
    check_eq({tag, "_rvalid"}, mgr_rvalid_o, 0);
    check_eq({tag, "_addr"}, obi_addr_o, 0);
    check_eq({tag, "_we"}, obi_we_o, 0);
    check_eq({tag, "_be"}, obi_be_o, 0);
    check_eq({tag, "_wdata"}, obi_wdata_o, 0);
    check_eq({tag, "_unexp"}, unexp_rsp_o, 0);
    check_eq({tag, "_rdata"}, mgr_rdata_o, 0);
  endtask

  // Assert reset between edges with busy inputs; outputs must clear at once.
  task automatic do_async_reset();
    #2;
    rst_ni = 1'b0;
    mgr_req_i = '1;
    obi_gnt_i = 1'b1;
    obi_rvalid_i = 1'b1;
    obi_rdata_i = 32'hdead_beef;
    #1;
    check_all_zero("async_rst");
    model_reset();
    mgr_req_i = '0;
    obi_gnt_i = 1'b0;
    obi_rvalid_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic run_cycle(input logic [N-1:0] req, input logic gnt, input logic rv);
    int sel;
    logic exp_req;
    logic [N-1:0] exp_gnt, exp_rv;
    @(negedge clk_i);
    mgr_req_i = req;
    obi_gnt_i = gnt;
    obi_rvalid_i = rv;
    obi_rdata_i = $urandom;
    obi_err_i = 1'($urandom);
    for (int i = 0; i < N; i++) begin
      mgr_addr_i[i*32 +: 32] = $urandom;
      mgr_wdata_i[i*32 +: 32] = $urandom;
      mgr_be_i[i*4 +: 4] = 4'($urandom);
      mgr_we_i[i] = 1'($urandom);
    end
    #1;
    sel = -1;
    if (lock_m >= 0) sel = lock_m;
    else for (int k = 0; k < N; k++)
      if (sel < 0 && req[(rr_m + k) % N]) sel = (rr_m + k) % N;
    exp_req = (req != 0) && (q_m.size() < M);
    exp_gnt = '0;
    if (exp_req && gnt) exp_gnt[sel] = 1'b1;
    exp_rv = '0;
    if (rv && q_m.size() > 0) exp_rv[q_m[0]] = 1'b1;

    check_eq("obi_req", obi_req_o, exp_req);
    check_eq("mgr_gnt", mgr_gnt_o, exp_gnt);
    check_eq("mgr_rvalid", mgr_rvalid_o, exp_rv);
    check_eq("unexp", unexp_rsp_o, unexp_m);
    if (exp_rv != 0) begin
      check_eq("rdata", mgr_rdata_o, obi_rdata_i);
      check_eq("err", mgr_err_o, obi_err_i);
    end
    if (exp_req) begin
      check_eq("addr", obi_addr_o, mgr_addr_i[sel*32 +: 32]);
      check_eq("wdata", obi_wdata_o, mgr_wdata_i[sel*32 +: 32]);
      check_eq("be", obi_be_o, mgr_be_i[sel*4 +: 4]);
      check_eq("we", obi_we_o, mgr_we_i[sel]);
    end
    obs_gnt = mgr_gnt_o;
    obs_rvalid = mgr_rvalid_o;
    obs_req = obi_req_o;
    obs_unexp = unexp_rsp_o;

    if (rv && q_m.size() == 0) unexp_m = 1'b1;
    if (exp_rv != 0) begin
      $display("[TB] t=%0t response -> mgr %0d rdata=%h", $time, q_m[0], obi_rdata_i);
      void'(q_m.pop_front());
    end
    if (exp_req) begin
      if (gnt) begin
        $display("[TB] t=%0t grant mgr %0d addr=%h", $time, sel, mgr_addr_i[sel*32 +: 32]);
        q_m.push_back(sel);
        rr_m = (sel + 1) % N;
        lock_m = -1;
      end else begin
        lock_m = sel;
      end
    end
  endtask

  initial begin
    logic [N-1:0] r;
    // Power-on reset with busy inputs.
    #2;
    mgr_req_i = '1;
    obi_gnt_i = 1'b1;
    obi_rvalid_i = 1'b1;
    #1;
    check_all_zero("por");
    mgr_req_i = '0;
    obi_gnt_i = 1'b0;
    obi_rvalid_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Lock on index 0 while ungranted, then index 1; handshake+pop with count 1.
    for (int i = 0; i < 3; i++) begin
      run_cycle(2'b01, 1'b0, 1'b0);
      check_eq("lock_wait_gnt", obs_gnt, 2'b00);
      check_eq("lock_wait_req", obs_req, 1'b1);
    end
    run_cycle(2'b11, 1'b0, 1'b0);
    check_eq("lock_hold_gnt", obs_gnt, 2'b00);
    run_cycle(2'b11, 1'b1, 1'b0);
    check_eq("lock_first_gnt", obs_gnt, 2'b01);
    run_cycle(2'b11, 1'b1, 1'b1);
    check_eq("lock_second_gnt", obs_gnt, 2'b10);
    check_eq("pushpop_rvalid", obs_rvalid, 2'b01);
    run_cycle(2'b00, 1'b0, 1'b1);
    check_eq("pushpop_drain", obs_rvalid, 2'b10);

    // Alternating grants with responses one cycle behind.
    for (int i = 0; i < 4; i++) begin
      run_cycle(2'b11, 1'b1, (i > 0));
      check_eq("alt_gnt", obs_gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
      if (i > 0) check_eq("alt_rvalid", obs_rvalid, ((i - 1) % 2 == 0) ? 2'b01 : 2'b10);
    end
    run_cycle(2'b00, 1'b0, 1'b1);
    check_eq("alt_drain", obs_rvalid, 2'b10);

    // Outstanding limit.
    run_cycle(2'b11, 1'b1, 1'b0);
    run_cycle(2'b11, 1'b1, 1'b0);
    run_cycle(2'b11, 1'b1, 1'b0);
    check_eq("full_req", obs_req, 1'b0);
    check_eq("full_gnt", obs_gnt, 2'b00);
    run_cycle(2'b11, 1'b1, 1'b1);
    check_eq("full_pop_req", obs_req, 1'b0);
    check_eq("full_pop_rvalid", obs_rvalid, 2'b01);
    run_cycle(2'b11, 1'b1, 1'b0);
    check_eq("refill_req", obs_req, 1'b1);
    check_eq("refill_gnt", obs_gnt, 2'b01);

    // Reset with two outstanding; late response is unexpected; grant restarts at 0.
    do_async_reset();
    run_cycle(2'b00, 1'b0, 1'b1);
    check_eq("late_rsp_rvalid", obs_rvalid, 2'b00);
    run_cycle(2'b11, 1'b1, 1'b0);
    check_eq("post_rst_gnt", obs_gnt, 2'b01);
    check_eq("unexp_sticky", obs_unexp, 1'b1);
    run_cycle(2'b00, 1'b0, 1'b0);
    check_eq("unexp_sticky2", obs_unexp, 1'b1);
    do_async_reset();

    // Random traffic against the model.
    for (int c = 0; c < 800; c++) begin
      if (c % 250 == 249) do_async_reset();
      r = N'($urandom);
      if (lock_m >= 0) r[lock_m] = 1'b1;
      run_cycle(r, 1'($urandom),
                (q_m.size() > 0) ? 1'($urandom) : ($urandom_range(19, 0) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
